// File: rtl/posit_chk_pkg.sv
// Shared types and default parameters for the posit adder result checker.
package posit_chk_pkg;

  localparam int unsigned DefN   = 32;
  localparam int unsigned DefEs  = 2;
  localparam int unsigned DefLat = 1;
  localparam int unsigned DefCw  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } chk_state_e;

endpackage

// File: rtl/posit_chk_delay.sv
// LAT-deep delay line carrying the golden value and a valid tag alongside the DUT pipeline.
module posit_chk_delay #(
  parameter int unsigned N   = 32,
  parameter int unsigned LAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] data_o,
  output logic         tag_o,
  output logic         pending_o
);

  logic [N-1:0]   data_q [LAT];
  logic [N-1:0]   data_d [LAT];
  logic [LAT-1:0] tag_q;
  logic [LAT-1:0] tag_d;

  always_comb begin
    data_d[0] = data_i;
    tag_d     = '0;
    tag_d[0]  = valid_i;
    for (int i = 1; i < LAT; i++) begin
      data_d[i] = data_q[i-1];
      tag_d[i]  = tag_q[i-1];
    end
  end

  // Tags still in flight once the head entry has been consumed this cycle.
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      pending_o = pending_o | tag_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tag_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q[LAT-1];
  assign tag_o  = tag_q[LAT-1];

endmodule

// File: rtl/posit_result_checker.sv
// Streams operands to a posit adder, compares its sums against golden values and keeps stats.
// Optional macro CHK_TOLERANCE_EN adds a tol input allowing compares with diff <= tol to pass.
module posit_result_checker
  import posit_chk_pkg::*;
#(
  parameter int unsigned N   = DefN,
  parameter int unsigned ES  = DefEs,
  parameter int unsigned LAT = DefLat,
  parameter int unsigned CW  = DefCw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] num_vec,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in1,
  input  logic [N-1:0]  in2,
  input  logic [N-1:0]  expected,
`ifdef CHK_TOLERANCE_EN
  input  logic [N-1:0]  tol,
`endif
  output logic [N-1:0]  dut_in1,
  output logic [N-1:0]  dut_in2,
  input  logic [N-1:0]  dut_out,
  output logic          mismatch,
  output logic [CW-1:0] mis_idx,
  output logic [N-1:0]  mis_diff,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] chk_cnt,
  output logic [N-1:0]  max_diff,
  output logic          busy,
  output logic          done
);

  if (LAT < 1 || LAT > 16 || ES >= N) begin : g_bad_param
    $error("posit_result_checker: LAT must be 1..16 and ES below N");
  end

  chk_state_e    state_q, state_d;
  logic [CW-1:0] num_vec_q, num_vec_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic [N-1:0]  dut_in1_q, dut_in1_d;
  logic [N-1:0]  dut_in2_q, dut_in2_d;
  logic          mismatch_q, mismatch_d;
  logic [CW-1:0] mis_idx_q, mis_idx_d;
  logic [N-1:0]  mis_diff_q, mis_diff_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] chk_cnt_q, chk_cnt_d;
  logic [N-1:0]  max_diff_q, max_diff_d;

  logic          xfer;
  logic [N-1:0]  exp_dly;
  logic          cmp_valid;
  logic          pending;
  logic [N-1:0]  diff;
  logic          fail;

  assign in_ready = (state_q == StRun);
  assign xfer     = in_valid && in_ready;

  posit_chk_delay #(
    .N   (N),
    .LAT (LAT)
  ) u_delay (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .valid_i   (xfer),
    .data_i    (expected),
    .data_o    (exp_dly),
    .tag_o     (cmp_valid),
    .pending_o (pending)
  );

  assign diff = (exp_dly >= dut_out) ? (exp_dly - dut_out) : (dut_out - exp_dly);

`ifdef CHK_TOLERANCE_EN
  assign fail = (diff > tol);
`else
  assign fail = (diff != '0);
`endif

  always_comb begin
    state_d    = state_q;
    num_vec_d  = num_vec_q;
    acc_cnt_d  = acc_cnt_q;
    dut_in1_d  = dut_in1_q;
    dut_in2_d  = dut_in2_q;
    mismatch_d = 1'b0;
    mis_idx_d  = mis_idx_q;
    mis_diff_d = mis_diff_q;
    err_cnt_d  = err_cnt_q;
    chk_cnt_d  = chk_cnt_q;
    max_diff_d = max_diff_q;

    // Compares retire in order, so the pre-increment compare count is the vector index.
    if (cmp_valid) begin
      if (chk_cnt_q != {CW{1'b1}}) chk_cnt_d = chk_cnt_q + CW'(1);
      if (diff > max_diff_q) max_diff_d = diff;
      if (fail) begin
        if (err_cnt_q != {CW{1'b1}}) err_cnt_d = err_cnt_q + CW'(1);
        mismatch_d = 1'b1;
        mis_idx_d  = chk_cnt_q;
        mis_diff_d = diff;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          num_vec_d  = num_vec;
          acc_cnt_d  = '0;
          mis_idx_d  = '0;
          mis_diff_d = '0;
          err_cnt_d  = '0;
          chk_cnt_d  = '0;
          max_diff_d = '0;
          state_d    = (num_vec == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (xfer) begin
          dut_in1_d = in1;
          dut_in2_d = in2;
          acc_cnt_d = acc_cnt_q + CW'(1);
          if (acc_cnt_q + CW'(1) == num_vec_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!pending) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      num_vec_q  <= '0;
      acc_cnt_q  <= '0;
      dut_in1_q  <= '0;
      dut_in2_q  <= '0;
      mismatch_q <= 1'b0;
      mis_idx_q  <= '0;
      mis_diff_q <= '0;
      err_cnt_q  <= '0;
      chk_cnt_q  <= '0;
      max_diff_q <= '0;
    end else begin
      state_q    <= state_d;
      num_vec_q  <= num_vec_d;
      acc_cnt_q  <= acc_cnt_d;
      dut_in1_q  <= dut_in1_d;
      dut_in2_q  <= dut_in2_d;
      mismatch_q <= mismatch_d;
      mis_idx_q  <= mis_idx_d;
      mis_diff_q <= mis_diff_d;
      err_cnt_q  <= err_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
      max_diff_q <= max_diff_d;
    end
  end

  assign dut_in1  = dut_in1_q;
  assign dut_in2  = dut_in2_q;
  assign mismatch = mismatch_q;
  assign mis_idx  = mis_idx_q;
  assign mis_diff = mis_diff_q;
  assign err_cnt  = err_cnt_q;
  assign chk_cnt  = chk_cnt_q;
  assign max_diff = max_diff_q;
  assign busy     = (state_q == StRun) || (state_q == StDrain);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_posit_result_checker.sv
// Scoreboard bench for posit_result_checker with a LAT=2 stand-in DUT replaying chosen sums.
module tb_posit_result_checker;

  localparam int Lat = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0, in2 = '0, expected = '0;
  logic [31:0] dut_in1, dut_in2, dut_out;
  logic        mismatch;
  logic [15:0] mis_idx, err_cnt, chk_cnt;
  logic [31:0] mis_diff, max_diff;
  logic        busy, done;
  logic [31:0] resp = '0;
`ifdef CHK_TOLERANCE_EN
  logic [31:0] tol = '0;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {int idx; int diff;} mis_rec_t;
  typedef struct {int chk; int err; int maxd;} done_rec_t;
  mis_rec_t  mis_q[$];
  done_rec_t done_q[$];

  always #5 clk = ~clk;

  posit_result_checker #(
    .N   (32),
    .ES  (2),
    .LAT (Lat),
    .CW  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_vec  (num_vec),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .expected (expected),
`ifdef CHK_TOLERANCE_EN
    .tol      (tol),
`endif
    .dut_in1  (dut_in1),
    .dut_in2  (dut_in2),
    .dut_out  (dut_out),
    .mismatch (mismatch),
    .mis_idx  (mis_idx),
    .mis_diff (mis_diff),
    .err_cnt  (err_cnt),
    .chk_cnt  (chk_cnt),
    .max_diff (max_diff),
    .busy     (busy),
    .done     (done)
  );

  // Stand-in adder: the sum chosen per vector emerges Lat cycles after the operand edge.
  logic [31:0] pipe [Lat];
  always @(posedge clk) begin
    pipe[0] <= (in_valid && in_ready) ? resp : 32'hdeadbeef;
    for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
  end
  assign dut_out = pipe[Lat-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every mismatch pulse and on every rise of done.
  logic done_d = 1'b0;
  always @(negedge clk) begin
    if (mismatch === 1'b1) begin
      if (mis_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_mismatch actual idx=%0d diff=%0d required none", mis_idx,
                 mis_diff);
      end else begin
        mis_rec_t r;
        r = mis_q.pop_front();
        chk("sb_mis_idx", 32'(mis_idx), 32'(r.idx));
        chk("sb_mis_diff", mis_diff, 32'(r.diff));
      end
    end
    if (done === 1'b1 && !done_d) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual done=1 required no run end");
      end else begin
        done_rec_t d;
        d = done_q.pop_front();
        chk("sb_chk_cnt", 32'(chk_cnt), 32'(d.chk));
        chk("sb_err_cnt", 32'(err_cnt), 32'(d.err));
        chk("sb_max_diff", max_diff, 32'(d.maxd));
      end
    end
    done_d = done;
  end

  task automatic do_start(input int n);
    start = 1'b1;
    num_vec = 16'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                      input logic [31:0] r);
    in_valid = 1'b1;
    in1 = a;
    in2 = b;
    expected = e;
    resp = r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_done actual done=0 required done=1 within %0d cycles", bound);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_chk_cnt", 32'(chk_cnt), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_max_diff", max_diff, 0);
    chk("rst_dut_in1", dut_in1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three exact sums; done lands two edges after the third transfer.
    done_q.push_back('{chk: 3, err: 0, maxd: 0});
    do_start(3);
    chk("run_in_ready", 32'(in_ready), 1);
    chk("run_busy", 32'(busy), 1);
    send(32'd1, 32'd2, 32'd3, 32'd3);
    chk("dut_in1_load", dut_in1, 32'd1);
    chk("dut_in2_load", dut_in2, 32'd2);
    send(32'd10, 32'd20, 32'd30, 32'd30);
    send(32'd5, 32'd6, 32'd11, 32'd11);
    chk("done_edge0", 32'(done), 0);
    @(negedge clk);
    chk("done_edge1", 32'(done), 0);
    @(negedge clk);
    chk("done_edge2", 32'(done), 1);
    chk("done_not_busy", 32'(busy), 0);

    // Vector 1 off by one ulp.
    mis_q.push_back('{idx: 1, diff: 1});
    done_q.push_back('{chk: 3, err: 1, maxd: 1});
    do_start(3);
    chk("restart_clr_chk", 32'(chk_cnt), 0);
    send(32'h3f800000, 32'h00000001, 32'h3f800001, 32'h3f800001);
    send(32'h20000000, 32'h20000000, 32'h40000000, 32'h40000001);
    send(32'h11111111, 32'h22222222, 32'h33333333, 32'h33333333);
    wait_done(10);
    chk("mis_idx_v1", 32'(mis_idx), 1);
    chk("mis_diff_v1", mis_diff, 1);
    chk("err_cnt_v1", 32'(err_cnt), 1);

    // Bubble between vectors, plus a start pulse mid-run that must be ignored.
    done_q.push_back('{chk: 2, err: 0, maxd: 0});
    do_start(2);
    chk("restart_clr_err", 32'(err_cnt), 0);
    chk("restart_clr_mis_idx", 32'(mis_idx), 0);
    chk("restart_clr_mis_diff", mis_diff, 0);
    chk("restart_clr_max", max_diff, 0);
    send(32'd7, 32'd8, 32'd15, 32'd15);
    start = 1'b1;
    num_vec = 16'd7;
    resp = 32'h0badf00d;
    @(negedge clk);
    start = 1'b0;
    chk("hold_dut_in1", dut_in1, 32'd7);
    chk("busy_after_start", 32'(busy), 1);
    send(32'd9, 32'd9, 32'd18, 32'd18);
    wait_done(10);
    chk("bubble_chk_cnt", 32'(chk_cnt), 2);

    // Diffs in both directions; max tracks the larger one.
    mis_q.push_back('{idx: 0, diff: 10});
    mis_q.push_back('{idx: 1, diff: 7});
    done_q.push_back('{chk: 3, err: 2, maxd: 10});
    do_start(3);
    send(32'd0, 32'd0, 32'd100, 32'd90);
    send(32'd0, 32'd0, 32'd5, 32'd12);
    send(32'd0, 32'd0, 32'd42, 32'd42);
    wait_done(10);
    chk("last_mis_idx", 32'(mis_idx), 1);
    chk("last_mis_diff", mis_diff, 7);
    chk("max_diff_10", max_diff, 10);

    // Reset during DRAIN discards both failing compares.
    do_start(2);
    send(32'd1, 32'd1, 32'd2, 32'd3);
    send(32'd2, 32'd2, 32'd4, 32'd5);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_in_ready", 32'(in_ready), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_chk", 32'(chk_cnt), 0);
    chk("mid_rst_dut_in1", dut_in1, 0);
    chk("mid_rst_max", max_diff, 0);
    repeat (4) @(negedge clk);
    chk("post_rst_chk", 32'(chk_cnt), 0);
    chk("post_rst_err", 32'(err_cnt), 0);

    // Empty run goes straight to DONE.
    done_q.push_back('{chk: 0, err: 0, maxd: 0});
    do_start(0);
    chk("zero_done", 32'(done), 1);
    chk("zero_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("zero_in_ready_2", 32'(in_ready), 0);

`ifdef CHK_TOLERANCE_EN
    tol = 32'd2;
    mis_q.push_back('{idx: 1, diff: 3});
    done_q.push_back('{chk: 2, err: 1, maxd: 3});
    do_start(2);
    send(32'd0, 32'd0, 32'd50, 32'd52);
    send(32'd0, 32'd0, 32'd50, 32'd47);
    wait_done(10);
    chk("tol_max_diff", max_diff, 3);
    chk("tol_err_cnt", 32'(err_cnt), 1);
`endif

    repeat (2) @(negedge clk);
    chk("sb_mis_drained", 32'(mis_q.size()), 0);
    chk("sb_done_drained", 32'(done_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit_result_checker.md
POSIT_RESULT_CHECKER -- requirements
Module: posit_result_checker

Interface
REQ-001 Parameter N, default 32, posit word width in bits.
REQ-002 Parameter ES, default 2, posit exponent size; carried only for reporting and package typing.
REQ-003 Parameter LAT, default 1, DUT latency in cycles; legal range 1..16.
REQ-004 Parameter CW, default 16, width of the vector, error and index counters.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins a run.
REQ-008 num_vec  in  CW  number of vectors in the run, sampled on start.
REQ-009 in_valid  in  1  stimulus vector present.
REQ-010 in_ready  out  1  checker accepts the vector this cycle.
REQ-011 in1, in2, expected  in  N each  operands and golden sum.
REQ-012 dut_in1, dut_in2  out  N each  registered operands to DUT.
REQ-013 dut_out  in  N  DUT sum.
REQ-014 mismatch  out  1  one-cycle pulse on a failing compare.
REQ-015 mis_idx, mis_diff  out  CW, N  index and magnitude of the latest failure.
REQ-016 err_cnt, chk_cnt  out  CW each  failures and compares done.
REQ-017 max_diff  out  N  largest diff seen in the run.
REQ-018 busy, done  out  1 each  run in progress; run complete.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; start in IDLE or DONE enters RUN and clears all counters, max_diff and mis_* in the same edge.
REQ-020 start with num_vec=0 enters DONE directly.
REQ-021 in_ready equals 1 only in RUN; transfer occurs when in_valid and in_ready are both 1.
REQ-022 On transfer, dut_in1/dut_in2 take in1/in2 at that edge; with no transfer they hold.
REQ-023 expected and a valid tag enter a LAT-deep delay line on transfer; bubbles enter with tag 0.
REQ-024 dut_out is compared with the delay-line output exactly LAT cycles after the operand edge, only when the tag is 1.
REQ-025 diff is the unsigned N-bit magnitude |expected - dut_out|; compare fails when diff is nonzero.
REQ-026 Each compare increments chk_cnt; each failure increments err_cnt, pulses mismatch, loads mis_idx with the vector index (0-based) and mis_diff with diff.
REQ-027 err_cnt and chk_cnt saturate at all-ones.
REQ-028 max_diff updates when diff exceeds it.
REQ-029 RUN moves to DRAIN on the edge that accepts vector num_vec; DRAIN moves to DONE when the delay line holds no tags.
REQ-030 done is 1 only in DONE; busy is 1 in RUN and DRAIN.
REQ-031 start during RUN or DRAIN is ignored.

Reset
REQ-032 While rst_n is 0 at a clock edge: state IDLE, all outputs 0, and delay-line tags cleared; a reset mid-run discards in-flight compares.

Configuration
REQ-033 With CHK_TOLERANCE_EN defined, input port tol (N bits) exists and a compare passes when diff is <= tol; without it, the port is absent and only diff=0 passes.

Structure
REQ-034 Package posit_chk_pkg holds the FSM state enum and the default N, ES, LAT and CW constants.
REQ-035 Sub-module posit_chk_delay implements the LAT-deep expected/tag delay line; the FSM, counters and compare stay in the top module.

Verification
REQ-036 LAT=2, num_vec=3, three exact DUT sums -> chk_cnt=3, err_cnt=0, done on the second edge after the third transfer.
REQ-037 Vector 1 DUT output 32'h40000001 vs expected 32'h40000000 -> mismatch pulse, mis_idx=1, mis_diff=1, err_cnt=1.
REQ-038 in_valid toggled 1,0,1 -> bubbles do not compare; chk_cnt=2.
REQ-039 rst_n=0 for one cycle during DRAIN -> IDLE; all outputs 0; no later compare.
REQ-040 With CHK_TOLERANCE_EN and tol=2, diff=2 -> pass; diff=3 -> fail; max_diff=3.
REQ-041 start with num_vec=0 -> DONE next edge; in_ready is never 1.
